aes_round_pipe: RTL and testbench

Parametrised, stallable AES-128 round engine for the encryption datapath. Each accepted beat carries LANES independent 128-bit states, their round keys, a per-beat round mode (full round, final round or key-add-only whitening) and a tag. Results appear after a fixed 3-cycle pipeline with valid/ready backpressure. Replaces the fixed full/final round pair: one instance serves every round of an iterative or unrolled cipher.

---
 rtl/aes_pkg.sv | 56 +++++
 rtl/aes_round_lane.sv | 89 ++++++++
 rtl/aes_round_pipe.sv | 79 +++++++
 tb/tb_aes_round_pipe.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aes_pkg
// Description : Shared AES-128 round helpers: round-mode encodings, S-box,
//               GF(2^8) multiply-by-2/3 and the FIPS-197 byte-position helper.
// Revision    : 1.0 - initial release
// ============================================================================
package aes_pkg;

  // Round modes carried with every beat; the remaining encoding (3) runs
  // a full round.
  localparam logic [1:0] MODE_FULL  = 2'd0;
  localparam logic [1:0] MODE_FINAL = 2'd1;
  localparam logic [1:0] MODE_ARK   = 2'd2;

  // Forward S-box, entry 0x00 in the most significant byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TABLE[2047 - 8*int'(b) -: 8];
  endfunction

  // Multiply by x modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul3(input logic [7:0] b);
    return xtime(b) ^ b;
  endfunction

  // MSB position of the byte at (row, col) inside a 128-bit lane;
  // byte i = 4*col + row sits at bits [127-8i -: 8].
  function automatic int byte_msb(input int row, input int col);
    return 127 - 8 * (4 * col + row);
  endfunction

endpackage
`default_nettype wire

// File: rtl/aes_round_lane.sv
`default_nettype none
// ============================================================================
// Module      : aes_round_lane
// Description : One 128-bit AES round datapath split over three registers:
//               S1 SubBytes, S2 ShiftRows/MixColumns, S3 AddRoundKey.
//               Ports: clk/rst, en_i (advance), mode_s0_i (mode of the
//               incoming beat), mode_s1_i (mode of the beat in S1),
//               state_i/key_i (incoming lane), state_o (S3 result).
// Revision    : 1.0 - initial release
// ============================================================================
module aes_round_lane
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  input  logic [1:0]   mode_s0_i,
  input  logic [1:0]   mode_s1_i,
  input  logic [127:0] state_i,
  input  logic [127:0] key_i,
  output logic [127:0] state_o
);

  logic [127:0] s1_data_q, s1_key_q;
  logic [127:0] s2_data_q, s2_key_q;
  logic [127:0] s3_data_q;
  logic [127:0] s1_data_d, s2_data_d, s3_data_d;
  logic [127:0] shifted, mixed;
  logic [7:0]   col [4];

  always_comb begin
    // SubBytes, skipped for key-add-only beats
    s1_data_d = state_i;
    if (mode_s0_i != MODE_ARK) begin
      for (int i = 0; i < 16; i++) begin
        s1_data_d[127-8*i -: 8] = sbox(state_i[127-8*i -: 8]);
      end
    end

    // ShiftRows: row r rotates left by r columns
    shifted = s1_data_q;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        shifted[byte_msb(r, c) -: 8] = s1_data_q[byte_msb(r, (c + r) % 4) -: 8];
      end
    end

    // MixColumns on the shifted state
    mixed = shifted;
    col   = '{default: 8'h00};
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        col[r] = shifted[byte_msb(r, c) -: 8];
      end
      for (int r = 0; r < 4; r++) begin
        mixed[byte_msb(r, c) -: 8] = xtime(col[r]) ^ gmul3(col[(r + 1) % 4])
                                   ^ col[(r + 2) % 4] ^ col[(r + 3) % 4];
      end
    end

    case (mode_s1_i)
      MODE_FINAL: s2_data_d = shifted;
      MODE_ARK:   s2_data_d = s1_data_q;
      default:    s2_data_d = mixed;
    endcase

    s3_data_d = s2_data_q ^ s2_key_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_data_q <= '0;
      s1_key_q  <= '0;
      s2_data_q <= '0;
      s2_key_q  <= '0;
      s3_data_q <= '0;
    end else if (en_i) begin
      s1_data_q <= s1_data_d;
      s1_key_q  <= key_i;
      s2_data_q <= s2_data_d;
      s2_key_q  <= s1_key_q;
      s3_data_q <= s3_data_d;
    end
  end

  assign state_o = s3_data_q;

endmodule
`default_nettype wire

// File: rtl/aes_round_pipe.sv
`default_nettype none
// ============================================================================
// Module      : aes_round_pipe
// Description : Stallable 3-stage AES-128 round engine, LANES blocks per beat.
//               Ports: clk/rst, in_valid/in_ready/in_mode/in_tag/in_state/
//               in_key (input beat), out_valid/out_ready/out_tag/out_state
//               (result beat, driven straight from the S3 registers).
// Revision    : 1.0 - initial release
// ============================================================================
module aes_round_pipe
  import aes_pkg::*;
#(
  parameter int LANES = 1,
  parameter int TAG_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           in_mode,
  input  logic [TAG_W-1:0]     in_tag,
  input  logic [LANES*128-1:0] in_state,
  input  logic [LANES*128-1:0] in_key,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [TAG_W-1:0]     out_tag,
  output logic [LANES*128-1:0] out_state
);

  logic             stall;
  logic             s1_valid_q, s2_valid_q, s3_valid_q;
  logic [TAG_W-1:0] s1_tag_q, s2_tag_q, s3_tag_q;
  logic [1:0]       s1_mode_q;

  // The whole pipe freezes only when a finished result is refused; bubbles
  // are held in place rather than squeezed out.
  assign stall    = s3_valid_q & ~out_ready;
  assign in_ready = ~stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s3_valid_q <= 1'b0;
      s1_tag_q   <= '0;
      s2_tag_q   <= '0;
      s3_tag_q   <= '0;
      s1_mode_q  <= MODE_FULL;
    end else if (!stall) begin
      s1_valid_q <= in_valid;
      s2_valid_q <= s1_valid_q;
      s3_valid_q <= s2_valid_q;
      s1_tag_q   <= in_tag;
      s2_tag_q   <= s1_tag_q;
      s3_tag_q   <= s2_tag_q;
      s1_mode_q  <= in_mode;
    end
  end

  generate
    for (genvar n = 0; n < LANES; n++) begin : g_lane
      aes_round_lane u_lane (
        .clk       (clk),
        .rst       (rst),
        .en_i      (~stall),
        .mode_s0_i (in_mode),
        .mode_s1_i (s1_mode_q),
        .state_i   (in_state[128*n +: 128]),
        .key_i     (in_key[128*n +: 128]),
        .state_o   (out_state[128*n +: 128])
      );
    end
  endgenerate

  assign out_valid = s3_valid_q;
  assign out_tag   = s3_tag_q;

endmodule
`default_nettype wire

// File: tb/tb_aes_round_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes_round_pipe
// Description : Scoreboard bench for aes_round_pipe with two lanes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_round_pipe;

  localparam int LANES = 2;
  localparam int TAG_W = 4;
  localparam int W     = LANES * 128;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_mode;
  logic [TAG_W-1:0] in_tag;
  logic [W-1:0]     in_state;
  logic [W-1:0]     in_key;
  logic             out_valid;
  logic             out_ready;
  logic [TAG_W-1:0] out_tag;
  logic [W-1:0]     out_state;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [W-1:0]     data;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   tests_run = 0;
  int   fails     = 0;
  int   rx_cnt    = 0;

  localparam logic [127:0] V1_ST  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] V1_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] V1_OUT = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] V2_KEY = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] V2_OUT = 128'ha49c7ff2689f352b6b5bea43026a5049;
  localparam logic [127:0] ALL63  = {16{8'h63}};

  aes_round_pipe #(.LANES(LANES), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mode   (in_mode),
    .in_tag    (in_tag),
    .in_state  (in_state),
    .in_key    (in_key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_tag   (out_tag),
    .out_state (out_state)
  );

  always #5 clk = ~clk;

  // Scoreboard monitor: a result consumed at the coming rising edge is popped
  // and compared here.
  always @(negedge clk) begin
    #2;
    if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      tests_run++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_output: got tag %0h data %h, no result expected", out_tag, out_state);
      end else begin
        mon_e = sb.pop_front();
        rx_cnt++;
        if (out_tag !== mon_e.tag || out_state !== mon_e.data) begin
          fails++;
          $display("FAIL scoreboard: got tag %0h data %h, expected tag %0h data %h",
                   out_tag, out_state, mon_e.tag, mon_e.data);
        end
      end
    end
  end

  // Presents one beat starting at the current falling edge and returns at the
  // falling edge after it is accepted, leaving in_valid low.
  task automatic send_beat(input logic [1:0] m, input logic [TAG_W-1:0] t,
                           input logic [W-1:0] st, input logic [W-1:0] k,
                           input logic [W-1:0] exp_data);
    int guard = 0;
    in_valid = 1'b1;
    in_mode  = m;
    in_tag   = t;
    in_state = st;
    in_key   = k;
    #1;
    while (in_ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      #1;
      guard++;
    end
    if (guard >= 50) begin
      tests_run++;
      fails++;
      $display("FAIL send_timeout: in_ready stayed %b, required 1", in_ready);
    end else begin
      sb.push_back('{tag: t, data: exp_data});
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    while (sb.size() != 0 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    tests_run++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d results outstanding, required 0", sb.size());
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_mode   = 2'd0;
    in_tag    = '0;
    in_state  = '0;
    in_key    = '0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || out_tag !== '0 || out_state !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got valid %b tag %0h state %h, required 0/0/0", out_valid, out_tag, out_state);
    end
    tests_run++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_in_ready: got %b, required 1", in_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_ark_latency();
    int cnt = 1;
    send_beat(2'd2, 4'h1, {V1_ST, V1_ST}, {V1_KEY, V1_KEY}, {V1_OUT, V1_OUT});
    while (out_valid !== 1'b1 && cnt < 10) begin
      @(negedge clk);
      cnt++;
    end
    tests_run++;
    if (cnt != 3) begin
      fails++;
      $display("FAIL ark_latency: got %0d cycles, required 3", cnt);
    end
    drain();
  endtask

  task automatic test_full_round();
    send_beat(2'd0, 4'h2, {V1_OUT, V1_OUT}, {V2_KEY, V2_KEY}, {V2_OUT, V2_OUT});
    drain();
  endtask

  task automatic test_zero_modes();
    send_beat(2'd1, 4'h3, '0, '0, {ALL63, ALL63});
    send_beat(2'd0, 4'h4, '0, '0, {ALL63, ALL63});
    send_beat(2'd3, 4'h5, '0, '0, {ALL63, ALL63});
    drain();
  endtask

  task automatic test_back_to_back();
    int              sent = 0;
    int              rx0  = rx_cnt;
    int              stable_checks = 0;
    logic            held_ok = 1'b0;
    logic [W-1:0]    held_state = '0;
    logic [TAG_W-1:0] held_tag  = '0;
    logic [W-1:0]    st, k;
    for (int c = 0; c < 40; c++) begin
      out_ready = !(c >= 4 && c < 8);
      if (sent < 5) begin
        for (int j = 0; j < W / 32; j++) begin
          st[32*j +: 32] = $urandom();
          k[32*j +: 32]  = $urandom();
        end
        in_valid = 1'b1;
        in_mode  = 2'd2;
        in_tag   = TAG_W'(sent + 1);
        in_state = st;
        in_key   = k;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      tests_run++;
      if (in_ready !== !(out_valid && !out_ready)) begin
        fails++;
        $display("FAIL b2b_in_ready: cycle %0d got %b with out_valid %b out_ready %b", c, in_ready, out_valid, out_ready);
      end
      if (in_valid && in_ready) begin
        sb.push_back('{tag: in_tag, data: in_state ^ in_key});
        sent++;
      end
      if (out_valid && !out_ready) begin
        if (held_ok) begin
          tests_run++;
          stable_checks++;
          if (out_state !== held_state || out_tag !== held_tag) begin
            fails++;
            $display("FAIL b2b_stall_stable: got tag %0h state %h, required tag %0h state %h",
                     out_tag, out_state, held_tag, held_state);
          end
        end
        held_ok    = 1'b1;
        held_state = out_state;
        held_tag   = out_tag;
      end else begin
        held_ok = 1'b0;
      end
      @(negedge clk);
      if (sent == 5 && sb.size() == 0) break;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain();
    tests_run++;
    if (rx_cnt - rx0 != 5 || stable_checks < 2) begin
      fails++;
      $display("FAIL b2b_count: got %0d results and %0d stall checks, required 5 and >=2", rx_cnt - rx0, stable_checks);
    end
  endtask

  task automatic test_lanes();
    send_beat(2'd2, 4'h6, {128'h0, V1_ST}, {128'h0, V1_KEY}, {128'h0, V1_OUT});
    send_beat(2'd0, 4'h7, {128'h0, V1_OUT}, {128'h0, V2_KEY}, {ALL63, V2_OUT});
    drain();
  endtask

  task automatic test_mid_reset();
    int cnt = 1;
    send_beat(2'd2, 4'h8, {V1_ST, V1_ST}, {V1_KEY, V1_KEY}, {V1_OUT, V1_OUT});
    send_beat(2'd2, 4'h9, '0, {V1_KEY, V1_KEY}, {V1_KEY, V1_KEY});
    send_beat(2'd2, 4'ha, {V1_ST, V1_ST}, '0, {V1_ST, V1_ST});
    rst       = 1'b1;
    out_ready = 1'b0;
    sb.delete();
    @(negedge clk);
    rst       = 1'b0;
    out_ready = 1'b1;
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL mid_reset_flush: got out_valid %b in_ready %b, required 0 and 1", out_valid, in_ready);
    end
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      #1;
      tests_run++;
      if (out_valid !== 1'b0) begin
        fails++;
        $display("FAIL mid_reset_ghost: cycle %0d got out_valid %b tag %0h, required 0", c, out_valid, out_tag);
      end
    end
    @(negedge clk);
    send_beat(2'd2, 4'hb, {V1_ST, V1_ST}, {V1_KEY, V1_KEY}, {V1_OUT, V1_OUT});
    while (out_valid !== 1'b1 && cnt < 10) begin
      @(negedge clk);
      cnt++;
    end
    tests_run++;
    if (cnt != 3) begin
      fails++;
      $display("FAIL post_reset_latency: got %0d cycles, required 3", cnt);
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_ark_latency();
    test_full_round();
    test_zero_modes();
    test_back_to_back();
    test_lanes();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
`default_nettype wire
